// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: FSM state encoding and default counter width.
package period_meter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Brings the asynchronous pulse stream into the CLK domain and flags each rising edge
// as a single-cycle EDGE pulse, two cycles after the input is first sampled high.
module edge_sync (
  input  logic CLK,
  input  logic RES,
  input  logic D,
  output logic EDGE
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= D;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign EDGE = r_sync2 & ~r_prev;

endmodule

// File: rtl/period_meter.sv
// Measures the spacing, in CLK cycles, between rising edges of PULSE_IN and hands each
// result to a consumer over a VALID/ACK handshake, with lock detection and sticky error flags.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             EN,
  input  logic             PULSE_IN,
  input  logic             ACK,
  input  logic             CLR,
  output logic [WIDTH-1:0] N_OUT,
  output logic             VALID,
  output logic             LOCKED,
  output logic             OVF,
  output logic             LOST
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_edge;
  logic             w_arm_edge;
  logic             w_load;
  logic             w_ovf_evt;
  logic             w_cnt_run;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_n_out;
  logic [WIDTH-1:0] r_prev_res;
  logic             r_prev_vld;
  logic             r_valid;
  logic             r_locked;
  logic             r_ovf;
  logic             r_lost;

  edge_sync u_edge_sync (
    .CLK  (CLK),
    .RES  (RES),
    .D    (PULSE_IN),
    .EDGE (w_edge)
  );

  // State register
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; EN low overrides every state
  always_comb begin
    w_state_next = r_state;
    if (!EN) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = ARMED;
        ARMED:   if (w_edge) w_state_next = MEASURE;
        MEASURE: if (!w_edge && (r_cnt == CNT_MAX)) w_state_next = ARMED;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Decoded FSM actions driving the datapath
  always_comb begin
    w_arm_edge = 1'b0;
    w_load     = 1'b0;
    w_ovf_evt  = 1'b0;
    w_cnt_run  = 1'b0;
    if (EN) begin
      case (r_state)
        ARMED:   w_arm_edge = w_edge;
        MEASURE: begin
          w_load    = w_edge;
          w_ovf_evt = !w_edge && (r_cnt == CNT_MAX);
          w_cnt_run = !w_edge && (r_cnt != CNT_MAX);
        end
        default: ;
      endcase
    end
  end

  // Period counter and previous-result memory for lock detection
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_cnt      <= '0;
      r_prev_res <= '0;
      r_prev_vld <= 1'b0;
      r_locked   <= 1'b0;
    end else if (!EN) begin
      r_cnt      <= '0;
      r_prev_res <= '0;
      r_prev_vld <= 1'b0;
      r_locked   <= 1'b0;
    end else if (w_arm_edge) begin
      r_cnt <= CNT_ONE;
    end else if (w_load) begin
      r_cnt      <= CNT_ONE;
      r_prev_res <= r_cnt;
      r_prev_vld <= 1'b1;
      r_locked   <= r_prev_vld && (r_prev_res == r_cnt);
    end else if (w_ovf_evt) begin
      // Overflow returns to ARMED, so the next result starts a fresh lock history
      r_cnt      <= '0;
      r_prev_vld <= 1'b0;
      r_locked   <= 1'b0;
    end else if (w_cnt_run) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Result register and handshake; a load in the ACK cycle keeps VALID high
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_n_out <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_n_out <= r_cnt;
        r_valid <= 1'b1;
      end else if (ACK) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Sticky flags: a set event beats CLR in the same cycle
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_ovf  <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (CLR) begin
        r_ovf <= 1'b0;
      end
      if (w_load && r_valid && !ACK) begin
        r_lost <= 1'b1;
      end else if (CLR) begin
        r_lost <= 1'b0;
      end
    end
  end

  assign N_OUT  = r_n_out;
  assign VALID  = r_valid;
  assign LOCKED = r_locked;
  assign OVF    = r_ovf;
  assign LOST   = r_lost;

endmodule
